// File: rtl/execute_muldiv_if.sv
// Issue/writeback bundle between the scheduler and the mul/div execute unit.
interface execute_muldiv_if #(
  parameter int WIDTH_BRM = 4,
  parameter int WIDTH_REG = 7,
  parameter int WIDTH     = 1 + 7 + WIDTH_BRM + WIDTH_REG + 10 + 4 * 32
);
  logic [WIDTH-1:0]       i_instr;
  logic [WIDTH_BRM-1:0]   i_kill;
  logic [WIDTH_BRM-1:0]   i_resolve;
  logic                   o_ready;
  logic                   o_valid;
  logic [WIDTH_REG-1:0]   o_addr;
  logic [31:0]            o_data;
  logic [32+WIDTH_REG:0]  o_bypass;

  modport master (
    output i_instr, i_kill, i_resolve,
    input  o_ready, o_valid, o_addr, o_data, o_bypass
  );

  modport slave (
    input  i_instr, i_kill, i_resolve,
    output o_ready, o_valid, o_addr, o_data, o_bypass
  );
endinterface

// File: rtl/execute_muldiv.sv
// RV32M execute unit: multi-cycle multiply plus 32-step restoring divider,
// one operation in flight, squashed by branch-mask kills.
module execute_muldiv #(
  parameter int WIDTH_BRM = 4,
  parameter int WIDTH_REG = 7,
  parameter int MUL_LAT   = 3,
  parameter int WIDTH     = 1 + 7 + WIDTH_BRM + WIDTH_REG + 10 + 4 * 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  execute_muldiv_if.slave   io_bus
);

  localparam int OP2_LSB  = 32;
  localparam int IMM_LSB  = 64;
  localparam int FUNC_LSB = 96;
  localparam int PC_LSB   = 106;
  localparam int RD_LSB   = 138;
  localparam int BRM_LSB  = RD_LSB + WIDTH_REG;
  localparam int UOP_LSB  = BRM_LSB + WIDTH_BRM;
  localparam int VAL_BIT  = UOP_LSB + 7;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;

  logic [31:0]           r_op1;
  logic [31:0]           r_op2;
  logic [2:0]            r_fn;
  logic [WIDTH_REG-1:0]  r_rd;
  logic [WIDTH_BRM-1:0]  r_brmask;
  logic [4:0]            r_cnt;
  logic [31:0]           r_quo;
  logic [31:0]           r_rem;
  logic [31:0]           r_dvs;
  logic                  r_valid;
  logic [WIDTH_REG-1:0]  r_addr;
  logic [31:0]           r_data;

  logic                  w_val;
  logic [6:0]            w_uop;
  logic [WIDTH_BRM-1:0]  w_brm;
  logic [WIDTH_REG-1:0]  w_rd;
  logic [9:0]            w_func;
  logic [31:0]           w_op1;
  logic [31:0]           w_op2;
  logic                  w_accept;
  logic                  w_killed;
  logic                  w_in_signed;
  logic [31:0]           w_mag1;
  logic [31:0]           w_mag2;

  logic                  w_a_sgn;
  logic                  w_b_sgn;
  logic signed [65:0]    w_ma;
  logic signed [65:0]    w_mb;
  logic signed [65:0]    w_prod;
  logic [31:0]           w_mul_res;

  logic [33:0]           w_sub;
  logic                  w_div_signed;
  logic                  w_neg_q;
  logic                  w_neg_r;
  logic [31:0]           w_div_res;
  logic [31:0]           w_result;
  logic                  w_byp_v;
  logic                  w_unused;

  assign w_val  = io_bus.i_instr[VAL_BIT];
  assign w_uop  = io_bus.i_instr[UOP_LSB +: 7];
  assign w_brm  = io_bus.i_instr[BRM_LSB +: WIDTH_BRM];
  assign w_rd   = io_bus.i_instr[RD_LSB +: WIDTH_REG];
  assign w_func = io_bus.i_instr[FUNC_LSB +: 10];
  assign w_op2  = io_bus.i_instr[OP2_LSB +: 32];
  assign w_op1  = io_bus.i_instr[31:0];

  assign w_accept = (r_state == S_IDLE) && w_val && (w_uop == 7'b0110011) &&
                    (w_func[9:3] == 7'b0000001) && ((w_brm & io_bus.i_kill) == '0);
  // Kill is tested against the mask before this cycle's resolve clears bits.
  assign w_killed = (r_brmask & io_bus.i_kill) != '0;

  assign w_in_signed = ~w_func[0];
  assign w_mag1 = (w_in_signed && w_op1[31]) ? (~w_op1 + 32'd1) : w_op1;
  assign w_mag2 = (w_in_signed && w_op2[31]) ? (~w_op2 + 32'd1) : w_op2;

  assign w_a_sgn   = (r_fn == 3'd1) || (r_fn == 3'd2);
  assign w_b_sgn   = (r_fn == 3'd1);
  assign w_ma      = $signed({{34{w_a_sgn & r_op1[31]}}, r_op1});
  assign w_mb      = $signed({{34{w_b_sgn & r_op2[31]}}, r_op2});
  assign w_prod    = w_ma * w_mb;
  assign w_mul_res = (r_fn == 3'd0) ? w_prod[31:0] : w_prod[63:32];

  assign w_sub = {1'b0, r_rem, r_quo[31]} - {2'b00, r_dvs};

  // A zero divisor falls out of the datapath: every trial subtract succeeds
  // (quotient all ones) and the remainder ends as |op1|, re-signed below.
  assign w_div_signed = ~r_fn[0];
  assign w_neg_q   = w_div_signed && (r_op1[31] ^ r_op2[31]) && (r_op2 != '0);
  assign w_neg_r   = w_div_signed && r_op1[31];
  assign w_div_res = r_fn[1] ? (w_neg_r ? (~r_rem + 32'd1) : r_rem)
                             : (w_neg_q ? (~r_quo + 32'd1) : r_quo);

  assign w_result = (r_state == S_MUL) ? w_mul_res : w_div_res;
  assign w_byp_v  = (((r_state == S_MUL) && (r_cnt == '0)) || (r_state == S_FIX)) && !w_killed;

  assign w_unused = ^{io_bus.i_instr[IMM_LSB +: 32], io_bus.i_instr[PC_LSB +: 32],
                      w_sub[32], w_prod[65:64]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_func[2] ? S_DIV : S_MUL;
      S_MUL:  if (w_killed) w_next = S_IDLE;
              else if (r_cnt == '0) w_next = S_DONE;
      S_DIV:  if (w_killed) w_next = S_IDLE;
              else if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = w_killed ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_fn     <= '0;
      r_rd     <= '0;
      r_brmask <= '0;
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_valid  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_brmask <= r_brmask & ~io_bus.i_resolve;
      if (w_accept) begin
        r_op1    <= w_op1;
        r_op2    <= w_op2;
        r_fn     <= w_func[2:0];
        r_rd     <= w_rd;
        r_brmask <= w_brm & ~io_bus.i_resolve;
        r_cnt    <= w_func[2] ? 5'd31 : 5'(MUL_LAT - 2);
        r_quo    <= w_mag1;
        r_rem    <= '0;
        r_dvs    <= w_mag2;
      end else if (((r_state == S_MUL) || (r_state == S_DIV)) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 5'd1;
      end
      if (r_state == S_DIV) begin
        if (w_sub[33]) begin
          r_rem <= {r_rem[30:0], r_quo[31]};
          r_quo <= {r_quo[30:0], 1'b0};
        end else begin
          r_rem <= w_sub[31:0];
          r_quo <= {r_quo[30:0], 1'b1};
        end
      end
      r_valid <= (w_next == S_DONE);
      if (w_next == S_DONE) begin
        r_addr <= r_rd;
        r_data <= w_result;
      end
    end
  end

  assign io_bus.o_ready  = (r_state == S_IDLE);
  assign io_bus.o_valid  = r_valid;
  assign io_bus.o_addr   = r_addr;
  assign io_bus.o_data   = r_data;
  assign io_bus.o_bypass = {w_byp_v, r_rd, w_result};

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv: directed vectors, kill/reset sequences,
// and randomized operations against an arithmetic reference model.
module tb_execute_muldiv;
  localparam int WB = 4;
  localparam int WR = 7;
  localparam int ML = 3;
  localparam int W  = 1 + 7 + WB + WR + 10 + 4 * 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_muldiv_if #(.WIDTH_BRM(WB), .WIDTH_REG(WR), .WIDTH(W)) bus ();

  execute_muldiv #(.WIDTH_BRM(WB), .WIDTH_REG(WR), .MUL_LAT(ML), .WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0]   last_data;
  logic [WR-1:0] last_addr;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pkt(input logic v, input logic [6:0] uop,
                                       input logic [WB-1:0] brm, input logic [WR-1:0] rd,
                                       input logic [9:0] fc, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [31:0] pc  = $urandom;
    logic [31:0] imm = $urandom;
    return {v, uop, brm, rd, pc, fc, imm, b, a};
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ub = longint'({32'h0, b});
    longint p;
    longint unsigned up;
    logic ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    logic [31:0] r;
    case (fn)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : $signed(a) / $signed(b);
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : $signed(a) % $signed(b);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one op and follow it cycle by cycle; sample k is taken after the k-th edge
  // following the accept edge, with kill/resolve applied during that same period.
  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [WR-1:0] rd, input logic [WB-1:0] brm,
                        input int kill_at, input logic [WB-1:0] kill_m,
                        input int res_at, input logic [WB-1:0] res_m,
                        input logic [31:0] exp);
    int lat = fn[2] ? 34 : ML;
    logic alive = 1'b1;
    logic [WB-1:0] bm = brm;
    logic kill_now, e_ready, e_valid, e_byp;
    chk("ready_before_issue", bus.o_ready, 1);
    bus.i_kill    = '0;
    bus.i_resolve = '0;
    bus.i_instr   = pkt(1'b1, 7'b0110011, brm, rd, {7'b0000001, fn}, a, b);
    @(posedge clk); #1;
    bus.i_instr = pkt(1'b0, 7'b0110011, brm, rd, {7'b0000001, fn}, a, b);
    for (int k = 0; k <= lat + 1; k++) begin
      bus.i_kill    = (k == kill_at) ? kill_m : '0;
      bus.i_resolve = (k == res_at) ? res_m : '0;
      #1;
      kill_now = 1'b0;
      if (alive) begin
        e_ready  = (k >= lat);
        e_valid  = (k == lat - 1);
        kill_now = (k <= lat - 2) && ((bm & bus.i_kill) != '0);
        e_byp    = (k == lat - 2) && !kill_now;
      end else begin
        e_ready = 1'b1;
        e_valid = 1'b0;
        e_byp   = 1'b0;
      end
      chk("o_ready", bus.o_ready, e_ready);
      chk("o_valid", bus.o_valid, e_valid);
      chk("bypass_valid", bus.o_bypass[32+WR], e_byp);
      if (e_byp) begin
        chk("bypass_rd", bus.o_bypass[32 +: WR], rd);
        chk("bypass_data", bus.o_bypass[31:0], exp);
      end
      if (e_valid) begin
        last_data = exp;
        last_addr = rd;
      end
      if (e_valid || k == lat) begin
        chk("o_addr", bus.o_addr, last_addr);
        chk("o_data", bus.o_data, last_data);
      end
      if (kill_now) alive = 1'b0;
      bm = bm & ~bus.i_resolve;
      @(posedge clk); #1;
    end
    bus.i_kill    = '0;
    bus.i_resolve = '0;
    chk("hold_addr", bus.o_addr, last_addr);
    chk("hold_data", bus.o_data, last_data);
  endtask

  task automatic run_reject(input logic [W-1:0] p, input logic [WB-1:0] kill_m);
    bus.i_instr = p;
    bus.i_kill  = kill_m;
    @(posedge clk); #1;
    bus.i_instr = '0;
    bus.i_kill  = '0;
    for (int k = 0; k < 5; k++) begin
      chk("reject_ready", bus.o_ready, 1);
      chk("reject_valid", bus.o_valid, 0);
      @(posedge clk); #1;
    end
    chk("reject_data_hold", bus.o_data, last_data);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000};
    vecs[3]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD};
    vecs[4]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF};
    vecs[5]  = '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF};
    vecs[6]  = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h00000000};
    vecs[7]  = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000};
    vecs[8]  = '{3'd7, 32'd5,          32'd0,        32'd5};
    vecs[9]  = '{3'd6, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9};
    vecs[10] = '{3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF};
    vecs[11] = '{3'd4, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD};
    vecs[12] = '{3'd6, 32'd7,          32'hFFFFFFFE, 32'd1};
    vecs[13] = '{3'd4, 32'd0,          32'd0,        32'hFFFFFFFF};
    vecs[14] = '{3'd7, 32'd100,        32'd7,        32'd2};

    rst = 1'b1;
    bus.i_instr   = '0;
    bus.i_kill    = '0;
    bus.i_resolve = '0;
    last_data = '0;
    last_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_addr", bus.o_addr, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_bypass_valid", bus.o_bypass[32+WR], 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", bus.o_ready, 1);

    for (int i = 0; i < 15; i++)
      run_op(vecs[i].fn, vecs[i].a, vecs[i].b, WR'(i + 3), 4'b0000, -1, '0, -1, '0, vecs[i].exp);

    // Reset in the middle of a divide.
    bus.i_instr = pkt(1'b1, 7'b0110011, 4'b0000, 7'd9, 10'b0000001_100, 32'd100, 32'd7);
    @(posedge clk); #1;
    bus.i_instr = '0;
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.o_valid, 0);
    chk("midrst_addr", bus.o_addr, 0);
    chk("midrst_data", bus.o_data, 0);
    chk("midrst_ready", bus.o_ready, 1);
    chk("midrst_bypass_valid", bus.o_bypass[32+WR], 0);
    last_data = '0;
    last_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("postrst_no_valid", bus.o_valid, 0);
    end
    run_op(3'd0, 32'd12, 32'hFFFFFFFB, 7'd11, 4'b0000, -1, '0, -1, '0, 32'hFFFFFFC4);

    // Branch-mask kill and resolve sequences.
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 7'd20, 4'b0010, 10, 4'b0010, -1, '0, 32'hFFFFFFFD);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 7'd21, 4'b0010, 10, 4'b0010, 5, 4'b0010, 32'hFFFFFFFD);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 7'd22, 4'b0010, 7, 4'b0010, 7, 4'b0010, 32'hFFFFFFFD);
    run_op(3'd5, 32'd1000, 32'd9, 7'd23, 4'b0001, 12, 4'b0010, -1, '0, 32'd111);
    run_op(3'd4, 32'd1000, 32'd9, 7'd24, 4'b1000, 32, 4'b1000, -1, '0, 32'd111);
    run_op(3'd0, 32'd6, 32'd7, 7'd25, 4'b0100, ML - 2, 4'b0100, -1, '0, 32'd42);
    run_op(3'd0, 32'd6, 32'd7, 7'd26, 4'b0100, 0, 4'b0100, -1, '0, 32'd42);
    run_op(3'd0, 32'd6, 32'd7, 7'd27, 4'b0100, -1, '0, -1, '0, 32'd42);

    // Packets that must not be accepted.
    run_reject(pkt(1'b0, 7'b0110011, 4'b0000, 7'd1, 10'b0000001_000, 32'd3, 32'd4), '0);
    run_reject(pkt(1'b1, 7'b0010011, 4'b0000, 7'd1, 10'b0000001_000, 32'd3, 32'd4), '0);
    run_reject(pkt(1'b1, 7'b0110011, 4'b0000, 7'd1, 10'b0000000_000, 32'd3, 32'd4), '0);
    run_reject(pkt(1'b1, 7'b0110011, 4'b0101, 7'd1, 10'b0000001_100, 32'd3, 32'd4), 4'b0100);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  fn = 3'($urandom_range(7));
      logic [31:0] a  = pick();
      logic [31:0] b  = pick();
      run_op(fn, a, b, WR'($urandom), WB'($urandom), -1, '0, -1, '0, ref_res(fn, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
